// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM (PAUSED/RUN/ADJ) and MM:SS per-digit BCD counter.
// Optional lap hold on digit outputs when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1,
    input  logic       clk_2,
    input  logic       btn_pause,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap,
`endif
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       blink_min,
    output logic       blink_sec
);

    typedef enum logic [1:0] {PAUSED, RUN, ADJ} state_t;

    localparam logic [3:0] MIN_T_MAX = 4'(MAX_MIN / 10);
    localparam logic [3:0] MIN_O_MAX = 4'(MAX_MIN % 10);
    localparam logic [3:0] SEC_T_MAX = 4'(MAX_SEC / 10);
    localparam logic [3:0] SEC_O_MAX = 4'(MAX_SEC % 10);

    state_t     state, state_n;
    logic       clk_1_q, clk_2_q;
    logic       tick1, tick2;
    logic [3:0] mt, mo, st, so;
    logic [3:0] mt_n, mo_n, st_n, so_n;
    logic       sec_wrap, min_wrap, inc_sec, inc_min;

    assign tick1 = clk_1 & ~clk_1_q;
    assign tick2 = clk_2 & ~clk_2_q;

    always_comb begin
        state_n = state;
        case (state)
            PAUSED:  if (adj) state_n = ADJ; else if (btn_pause) state_n = RUN;
            RUN:     if (adj) state_n = ADJ; else if (btn_pause) state_n = PAUSED;
            ADJ:     if (!adj) state_n = PAUSED;
            default: state_n = PAUSED;
        endcase
    end

    // Increments are decided from the current state, not the next one.
    always_comb begin
        sec_wrap = (st == SEC_T_MAX) && (so == SEC_O_MAX);
        min_wrap = (mt == MIN_T_MAX) && (mo == MIN_O_MAX);
        inc_sec  = ((state == RUN) && tick1) || ((state == ADJ) && tick2 && !sel);
        inc_min  = ((state == RUN) && tick1 && sec_wrap) || ((state == ADJ) && tick2 && sel);
        mt_n = mt;
        mo_n = mo;
        st_n = st;
        so_n = so;
        if (inc_sec) begin
            if (sec_wrap) begin
                st_n = 4'd0;
                so_n = 4'd0;
            end else if (so == 4'd9) begin
                st_n = st + 4'd1;
                so_n = 4'd0;
            end else begin
                so_n = so + 4'd1;
            end
        end
        if (inc_min) begin
            if (min_wrap) begin
                mt_n = 4'd0;
                mo_n = 4'd0;
            end else if (mo == 4'd9) begin
                mt_n = mt + 4'd1;
                mo_n = 4'd0;
            end else begin
                mo_n = mo + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PAUSED;
            clk_1_q   <= clk_1;
            clk_2_q   <= clk_2;
            mt        <= 4'd0;
            mo        <= 4'd0;
            st        <= 4'd0;
            so        <= 4'd0;
            running   <= 1'b0;
            blink_min <= 1'b0;
            blink_sec <= 1'b0;
        end else begin
            state     <= state_n;
            clk_1_q   <= clk_1;
            clk_2_q   <= clk_2;
            mt        <= mt_n;
            mo        <= mo_n;
            st        <= st_n;
            so        <= so_n;
            running   <= (state_n == RUN);
            blink_min <= (state_n == ADJ) && sel;
            blink_sec <= (state_n == ADJ) && !sel;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_hold, lap_hold_n;

    // Hold only lives inside RUN; a lap press on the exit cycle just releases.
    always_comb begin
        lap_hold_n = lap_hold;
        if ((state != RUN) || (state_n != RUN))
            lap_hold_n = 1'b0;
        else if (btn_lap)
            lap_hold_n = ~lap_hold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_hold <= 1'b0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else begin
            lap_hold <= lap_hold_n;
            if (!lap_hold_n) begin
                min_tens <= mt_n;
                min_ones <= mo_n;
                sec_tens <= st_n;
                sec_ones <= so_n;
            end
        end
    end
`else
    assign min_tens = mt;
    assign min_ones = mo;
    assign sec_tens = st;
    assign sec_ones = so;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scenario bench for stopwatch_ctrl: expectations queued at stimulus time,
// popped and compared once the DUT has registered the result.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst, clk_1, clk_2, btn_pause, adj, sel;
`ifdef STOPWATCH_LAP_EN
    logic       btn_lap;
`endif
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, blink_min, blink_sec;
    logic [18:0] obs, exp_v;
    logic [18:0] sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.MAX_MIN(59), .MAX_SEC(59)) dut (
        .clk(clk), .rst(rst), .clk_1(clk_1), .clk_2(clk_2),
        .btn_pause(btn_pause),
`ifdef STOPWATCH_LAP_EN
        .btn_lap(btn_lap),
`endif
        .adj(adj), .sel(sel),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .blink_min(blink_min), .blink_sec(blink_sec)
    );

    assign obs = {min_tens, min_ones, sec_tens, sec_ones, running, blink_min, blink_sec};

    function automatic logic [18:0] mk(input int mm, input int ss, input logic r,
                                       input logic bm, input logic bs);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), r, bm, bs};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_1(input int n);
        for (int i = 0; i < n; i++) begin
            clk_1 = 1'b1; cyc();
            clk_1 = 1'b0; cyc();
        end
    endtask

    task automatic pulse_2(input int n);
        for (int i = 0; i < n; i++) begin
            clk_2 = 1'b1; cyc();
            clk_2 = 1'b0; cyc();
        end
    endtask

    task automatic press_pause();
        btn_pause = 1'b1; cyc();
        btn_pause = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0));
        clk_1 = 1'b1; cyc();
        clk_1 = 1'b0; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
        rst = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0));
        pulse_1(3);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL paused_no_count: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_run();
        sb.push_back(mk(0, 0, 1, 0, 0));
        press_pause(); cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL enter_run: got %h want %h", obs, exp_v); end
        sb.push_back(mk(0, 3, 1, 0, 0));
        pulse_1(3);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL run_3_ticks: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_wrap();
        adj = 1'b1; sel = 1'b1; cyc();
        sb.push_back(mk(59, 3, 0, 1, 0));
        pulse_2(59);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_min_59: got %h want %h", obs, exp_v); end
        sel = 1'b0; cyc();
        sb.push_back(mk(59, 59, 0, 0, 1));
        pulse_2(56);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_sec_59: got %h want %h", obs, exp_v); end
        adj = 1'b0; cyc();
        press_pause(); cyc();
        sb.push_back(mk(0, 0, 1, 0, 0));
        pulse_1(1);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_5959: got %h want %h", obs, exp_v); end
        adj = 1'b1; sel = 1'b0; cyc();
        pulse_2(59);
        adj = 1'b0; cyc();
        press_pause(); cyc();
        sb.push_back(mk(1, 0, 1, 0, 0));
        pulse_1(1);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL carry_0059: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_adjust();
        // tick1 on the cycle adj rises while running is still counted
        sb.push_back(mk(1, 1, 0, 1, 0));
        adj = 1'b1; sel = 1'b1; clk_1 = 1'b1; cyc();
        clk_1 = 1'b0; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_entry_tick: got %h want %h", obs, exp_v); end
        sb.push_back(mk(1, 1, 0, 1, 0));
        pulse_1(2);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_ignores_tick1: got %h want %h", obs, exp_v); end
        sb.push_back(mk(0, 1, 0, 1, 0));
        pulse_2(59);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_min_wrap: got %h want %h", obs, exp_v); end
        sb.push_back(mk(0, 1, 0, 0, 1));
        sel = 1'b0; cyc(); cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sel_no_inc: got %h want %h", obs, exp_v); end
        pulse_2(57);
        sb.push_back(mk(0, 1, 0, 0, 1));
        pulse_2(3);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_sec_wrap_no_carry: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_pause_collision();
        pulse_2(4);
        sb.push_back(mk(0, 5, 0, 0, 0));
        adj = 1'b0; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_exit: got %h want %h", obs, exp_v); end
        press_pause(); cyc();
        sb.push_back(mk(0, 6, 0, 0, 0));
        btn_pause = 1'b1; clk_1 = 1'b1; cyc();
        btn_pause = 1'b0; clk_1 = 1'b0; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL tick_with_pause: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_priority();
        sb.push_back(mk(0, 6, 0, 0, 1));
        adj = 1'b1; btn_pause = 1'b1; cyc();
        btn_pause = 1'b0; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_over_pause: got %h want %h", obs, exp_v); end
        sb.push_back(mk(0, 6, 0, 0, 0));
        press_pause(); cyc();
        adj = 1'b0; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_ignores_pause: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        press_pause(); cyc();
        sb.push_back(mk(0, 7, 1, 0, 0));
        pulse_1(1);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pre_reset_count: got %h want %h", obs, exp_v); end
        sb.push_back(mk(0, 0, 0, 0, 0));
        rst = 1'b1; clk_1 = 1'b1; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_mid_run: got %h want %h", obs, exp_v); end
        rst = 1'b0; clk_1 = 1'b0;
        adj = 1'b1; sel = 1'b0; cyc();
        sb.push_back(mk(0, 1, 0, 0, 1));
        clk_2 = 1'b1; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL adj_before_reset: got %h want %h", obs, exp_v); end
        clk_2 = 1'b0; cyc();
        sb.push_back(mk(0, 0, 0, 0, 0));
        rst = 1'b1; clk_2 = 1'b1; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_mid_adj: got %h want %h", obs, exp_v); end
        rst = 1'b0; adj = 1'b0; cyc();
        // clk_2 still high after reset: no stale edge may be seen
        adj = 1'b1; cyc(); cyc();
        sb.push_back(mk(0, 0, 0, 0, 1));
        clk_2 = 1'b0; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL no_tick_after_reset: got %h want %h", obs, exp_v); end
        adj = 1'b0; cyc();
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        adj = 1'b1; sel = 1'b0; cyc();
        pulse_2(10);
        adj = 1'b0; cyc();
        press_pause(); cyc();
        btn_lap = 1'b1; cyc();
        btn_lap = 1'b0;
        sb.push_back(mk(0, 10, 1, 0, 0));
        pulse_1(4);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lap_hold: got %h want %h", obs, exp_v); end
        sb.push_back(mk(0, 14, 1, 0, 0));
        btn_lap = 1'b1; cyc();
        btn_lap = 1'b0; cyc();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lap_release: got %h want %h", obs, exp_v); end
    endtask
`endif

    initial begin
        rst = 1'b1; clk_1 = 1'b0; clk_2 = 1'b0; btn_pause = 1'b0;
        adj = 1'b0; sel = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap = 1'b0;
`endif
        test_reset();
        test_run();
        test_wrap();
        test_adjust();
        test_pause_collision();
        test_priority();
        test_reset_mid();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
